// File: rtl/climate_ctrl.sv
// Setpoint/actuator controller behind the UART string interface: decodes
// two-digit commands, runs fan/humidifier hysteresis and a timed manual override.
module climate_ctrl #(
  parameter int DEF_MAX_TEMP     = 30,
  parameter int DEF_MIN_TEMP     = 20,
  parameter int DEF_MAX_HUM      = 70,
  parameter int DEF_MIN_HUM      = 40,
  parameter int TICK_CYCLES      = 1_000_000,
  parameter int MANUAL_TIMEOUT_S = 60
) (
  input  logic       clk_1Mhz,
  input  logic       rst,
  input  logic [7:0] chr_cmd,
  input  logic [7:0] chr_val0,
  input  logic [7:0] chr_val1,
  input  logic       rx_msg_done,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       sensor_valid,
  output logic       fan_state,
  output logic       hum_state,
  output logic [7:0] max_temp,
  output logic [7:0] min_temp,
  output logic [7:0] max_hum,
  output logic [7:0] min_hum,
  output logic       manual_mode,
  output logic       cmd_ack,
  output logic       cfg_err
);

  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int SEC_W  = $clog2(MANUAL_TIMEOUT_S + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(MANUAL_TIMEOUT_S - 1);

  typedef enum logic [1:0] {IDLE, DECODE, APPLY} state_t;

  state_t            state_q;
  logic              rxPrev_q;
  logic [7:0]        cmd_q, chr0_q, chr1_q;
  logic [6:0]        val_q;
  logic              dig0_q, dig1_q;
  logic [7:0]        maxTemp_q, minTemp_q, maxHum_q, minHum_q;
  logic              fan_q, hum_q, manual_q, ack_q, err_q;
  logic [TICK_W-1:0] tick_q;
  logic [SEC_W-1:0]  sec_q;

  logic [6:0] val_d;
  logic       dig0_d, dig1_d;
  logic [7:0] valExt;
  logic       digits, lSet, lClear, applyOk;

  always_comb begin
    dig0_d  = (chr0_q >= 8'h30) && (chr0_q <= 8'h39);
    dig1_d  = (chr1_q >= 8'h30) && (chr1_q <= 8'h39);
    val_d   = 7'(chr0_q[3:0]) * 7'd10 + 7'(chr1_q[3:0]);
    valExt  = {1'b0, val_q};
    digits  = dig0_q && dig1_q;
    lSet    = (chr0_q == 8'h30 || chr0_q == 8'h31) && (chr1_q == 8'h30 || chr1_q == 8'h31);
    lClear  = (chr0_q == 8'h2D) && dig1_q;
    applyOk = 1'b0;
    case (cmd_q)
      8'h41:   applyOk = digits && valExt <= 8'd50 && valExt > minTemp_q;
      8'h42:   applyOk = digits && valExt <= 8'd50 && valExt < maxTemp_q;
      8'h43:   applyOk = digits && valExt > minHum_q;
      8'h44:   applyOk = digits && valExt < maxHum_q;
      8'h4C:   applyOk = lSet || lClear;
      default: applyOk = 1'b0;
    endcase
  end

  // Later assignments in this block take priority, so an 'L' apply overrides
  // both the sensor update and a simultaneous timeout expiry.
  always_ff @(posedge clk_1Mhz) begin
    if (rst) begin
      state_q   <= IDLE;
      rxPrev_q  <= 1'b1;
      cmd_q     <= '0;
      chr0_q    <= '0;
      chr1_q    <= '0;
      val_q     <= '0;
      dig0_q    <= 1'b0;
      dig1_q    <= 1'b0;
      maxTemp_q <= 8'(DEF_MAX_TEMP);
      minTemp_q <= 8'(DEF_MIN_TEMP);
      maxHum_q  <= 8'(DEF_MAX_HUM);
      minHum_q  <= 8'(DEF_MIN_HUM);
      fan_q     <= 1'b0;
      hum_q     <= 1'b0;
      manual_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      tick_q    <= '0;
      sec_q     <= '0;
    end else begin
      rxPrev_q <= rx_msg_done;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;

      if (manual_q) begin
        if (tick_q == TICK_LAST) begin
          tick_q <= '0;
          if (sec_q == SEC_LAST) begin
            sec_q    <= '0;
            manual_q <= 1'b0;
          end else begin
            sec_q <= sec_q + 1'b1;
          end
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end else begin
        tick_q <= '0;
        sec_q  <= '0;
      end

      if (!manual_q && sensor_valid) begin
        if (temperature > maxTemp_q)      fan_q <= 1'b1;
        else if (temperature < minTemp_q) fan_q <= 1'b0;
        if (humidity < minHum_q)          hum_q <= 1'b1;
        else if (humidity >= maxHum_q)    hum_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rx_msg_done && !rxPrev_q) begin
            cmd_q   <= chr_cmd;
            chr0_q  <= chr_val0;
            chr1_q  <= chr_val1;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          val_q   <= val_d;
          dig0_q  <= dig0_d;
          dig1_q  <= dig1_d;
          state_q <= APPLY;
        end
        APPLY: begin
          state_q <= IDLE;
          ack_q   <= applyOk;
          err_q   <= !applyOk;
          if (applyOk) begin
            case (cmd_q)
              8'h41: maxTemp_q <= valExt;
              8'h42: minTemp_q <= valExt;
              8'h43: maxHum_q  <= valExt;
              8'h44: minHum_q  <= valExt;
              8'h4C: begin
                tick_q <= '0;
                sec_q  <= '0;
                if (lSet) begin
                  fan_q    <= chr0_q[0];
                  hum_q    <= chr1_q[0];
                  manual_q <= 1'b1;
                end else begin
                  manual_q <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fan_state   = fan_q;
  assign hum_state   = hum_q;
  assign max_temp    = maxTemp_q;
  assign min_temp    = minTemp_q;
  assign max_hum     = maxHum_q;
  assign min_hum     = minHum_q;
  assign manual_mode = manual_q;
  assign cmd_ack     = ack_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_climate_ctrl.sv
// Self-checking bench for climate_ctrl: directed scenarios plus randomized
// commands and sensor samples compared against a rule-level reference model.
module tb_climate_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] chr_cmd = '0, chr_val0 = '0, chr_val1 = '0;
  logic       rx_msg_done = 1'b1;
  logic [7:0] temperature = '0, humidity = '0;
  logic       sensor_valid = 1'b0;
  logic       fan_state, hum_state, manual_mode, cmd_ack, cfg_err;
  logic [7:0] max_temp, min_temp, max_hum, min_hum;

  int tests = 0;
  int fails = 0;

  int mMaxT = 30, mMinT = 20, mMaxH = 70, mMinH = 40;
  bit mFan = 0, mHum = 0, mManual = 0;

  climate_ctrl #(.TICK_CYCLES(10), .MANUAL_TIMEOUT_S(3)) dut (
    .clk_1Mhz(clk), .rst(rst), .chr_cmd(chr_cmd), .chr_val0(chr_val0),
    .chr_val1(chr_val1), .rx_msg_done(rx_msg_done), .temperature(temperature),
    .humidity(humidity), .sensor_valid(sensor_valid), .fan_state(fan_state),
    .hum_state(hum_state), .max_temp(max_temp), .min_temp(min_temp),
    .max_hum(max_hum), .min_hum(min_hum), .manual_mode(manual_mode),
    .cmd_ack(cmd_ack), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic bit isDig(input logic [7:0] c);
    return c >= 8'h30 && c <= 8'h39;
  endfunction

  // Reference model: applies the command rules to the model state, returns accept.
  task automatic modelCmd(input logic [7:0] c, v0, v1, output bit ok);
    bit dd;
    int v;
    dd = isDig(v0) && isDig(v1);
    v  = (int'(v0) - 48) * 10 + (int'(v1) - 48);
    ok = 0;
    if (c == "A" && dd && v <= 50 && v > mMinT) begin mMaxT = v; ok = 1; end
    else if (c == "B" && dd && v <= 50 && v < mMaxT) begin mMinT = v; ok = 1; end
    else if (c == "C" && dd && v > mMinH) begin mMaxH = v; ok = 1; end
    else if (c == "D" && dd && v < mMaxH) begin mMinH = v; ok = 1; end
    else if (c == "L") begin
      if ((v0 == "0" || v0 == "1") && (v1 == "0" || v1 == "1")) begin
        mFan = (v0 == "1"); mHum = (v1 == "1"); mManual = 1; ok = 1;
      end else if (v0 == "-" && isDig(v1)) begin
        mManual = 0; ok = 1;
      end
    end
  endtask

  task automatic modelSensor(input int t, input int h);
    if (!mManual) begin
      if (t > mMaxT) mFan = 1;
      else if (t < mMinT) mFan = 0;
      if (h < mMinH) mHum = 1;
      else if (h >= mMaxH) mHum = 0;
    end
  endtask

  // Sends one message; results sampled in the cycle after the APPLY edge.
  task automatic sendMsg(input logic [7:0] c, v0, v1, input bit svAtApply,
                         output logic ackSeen, output logic errSeen, output logic earlySeen);
    @(posedge clk); #1;
    chr_cmd = c; chr_val0 = v0; chr_val1 = v1; rx_msg_done = 1'b1;
    @(posedge clk); #1;
    rx_msg_done = 1'b0;
    earlySeen = cmd_ack | cfg_err;
    @(posedge clk); #1;
    earlySeen = earlySeen | cmd_ack | cfg_err;
    if (svAtApply) begin temperature = 8'd99; humidity = 8'd0; sensor_valid = 1'b1; end
    @(posedge clk); #1;
    sensor_valid = 1'b0;
    ackSeen = cmd_ack;
    errSeen = cfg_err;
  endtask

  task automatic sensorStep(input int t, input int h);
    @(posedge clk); #1;
    temperature = 8'(t); humidity = 8'(h); sensor_valid = 1'b1;
    @(posedge clk); #1;
    sensor_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic pulses;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    pulses = 1'b0;
    repeat (4) begin @(posedge clk); #1 pulses = pulses | cmd_ack | cfg_err; end
    tests++;
    if (pulses !== 1'b0) begin fails++; $display("[TB] FAIL reset_no_pulse got=%b want=0", pulses); end
    tests++;
    if ({max_temp, min_temp, max_hum, min_hum} !== {8'd30, 8'd20, 8'd70, 8'd40}) begin
      fails++; $display("[TB] FAIL reset_setpoints got=%0d/%0d/%0d/%0d want=30/20/70/40",
                        max_temp, min_temp, max_hum, min_hum);
    end
    tests++;
    if ({fan_state, hum_state, manual_mode} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_outputs got=%b%b%b want=000", fan_state, hum_state, manual_mode);
    end
    rx_msg_done = 1'b0;
  endtask

  task automatic test_setpoint;
    logic a, e, early;
    bit ok;
    sendMsg("A", "2", "8", 0, a, e, early);
    modelCmd("A", "2", "8", ok);
    tests++;
    if ({a, e, early} !== {1'b1, 1'b0, 1'b0}) begin
      fails++; $display("[TB] FAIL set_A28_ack got ack=%b err=%b early=%b want 1 0 0", a, e, early);
    end
    tests++;
    if (max_temp !== 8'd28) begin fails++; $display("[TB] FAIL set_A28_value got=%0d want=28", max_temp); end
    sendMsg("B", "2", "8", 0, a, e, early);
    modelCmd("B", "2", "8", ok);
    tests++;
    if ({a, e} !== 2'b01 || min_temp !== 8'd20) begin
      fails++; $display("[TB] FAIL set_B28_reject got ack=%b err=%b min=%0d want 0 1 20", a, e, min_temp);
    end
  endtask

  task automatic test_auto_hysteresis;
    int tSeq[3] = '{31, 25, 19};
    int hSeq[3] = '{39, 55, 70};
    bit fWant[3] = '{1, 1, 0};
    bit hWant[3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      sensorStep(tSeq[i], 55);
      modelSensor(tSeq[i], 55);
      tests++;
      if (fan_state !== fWant[i]) begin
        fails++; $display("[TB] FAIL hyst_temp%0d got fan=%b want=%b", tSeq[i], fan_state, fWant[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      sensorStep(25, hSeq[i]);
      modelSensor(25, hSeq[i]);
      tests++;
      if (hum_state !== hWant[i]) begin
        fails++; $display("[TB] FAIL hyst_hum%0d got hum=%b want=%b", hSeq[i], hum_state, hWant[i]);
      end
    end
  endtask

  task automatic test_manual;
    logic a, e, early;
    bit ok;
    sendMsg("L", "1", "0", 0, a, e, early);
    modelCmd("L", "1", "0", ok);
    tests++;
    if ({a, manual_mode, fan_state, hum_state} !== {1'b1, 1'b1, mFan, mHum}) begin
      fails++; $display("[TB] FAIL manual_L10 got ack=%b man=%b fan=%b hum=%b want 1 1 %b %b",
                        a, manual_mode, fan_state, hum_state, mFan, mHum);
    end
    sensorStep(10, 50);
    modelSensor(10, 50);
    tests++;
    if (fan_state !== mFan) begin fails++; $display("[TB] FAIL manual_ignores_sensor got fan=%b want=%b", fan_state, mFan); end
    sendMsg("L", "-", "0", 0, a, e, early);
    modelCmd("L", "-", "0", ok);
    tests++;
    if ({a, manual_mode, fan_state, hum_state} !== {1'b1, 1'b0, mFan, mHum}) begin
      fails++; $display("[TB] FAIL manual_exit got ack=%b man=%b fan=%b hum=%b want 1 0 %b %b",
                        a, manual_mode, fan_state, hum_state, mFan, mHum);
    end
  endtask

  task automatic test_timeout;
    logic a, e, early;
    bit ok;
    int dropAt;
    sendMsg("L", "0", "1", 0, a, e, early);
    modelCmd("L", "0", "1", ok);
    dropAt = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (!manual_mode) begin dropAt = i; break; end
    end
    tests++;
    if (dropAt != 30) begin fails++; $display("[TB] FAIL timeout_first got=%0d cycles want=30", dropAt); end
    mManual = 0;
    tests++;
    if ({fan_state, hum_state} !== {mFan, mHum}) begin
      fails++; $display("[TB] FAIL timeout_hold got fan=%b hum=%b want %b %b", fan_state, hum_state, mFan, mHum);
    end
    sendMsg("L", "0", "1", 0, a, e, early);
    modelCmd("L", "0", "1", ok);
    repeat (16) @(posedge clk);
    sendMsg("L", "0", "1", 0, a, e, early);
    tests++;
    if ({a, manual_mode} !== 2'b11) begin
      fails++; $display("[TB] FAIL timeout_restart_apply got ack=%b man=%b want 1 1", a, manual_mode);
    end
    dropAt = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (!manual_mode) begin dropAt = i; break; end
    end
    tests++;
    if (dropAt != 30) begin fails++; $display("[TB] FAIL timeout_restart got=%0d cycles want=30", dropAt); end
    mManual = 0;
  endtask

  task automatic test_simultaneous;
    logic a, e, early;
    bit ok;
    modelSensor(99, 0);
    sendMsg("L", "0", "0", 1, a, e, early);
    modelCmd("L", "0", "0", ok);
    tests++;
    if ({a, manual_mode, fan_state, hum_state} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("[TB] FAIL simul_L_vs_sensor got ack=%b man=%b fan=%b hum=%b want 1 1 0 0",
                        a, manual_mode, fan_state, hum_state);
    end
    sendMsg("L", "-", "3", 0, a, e, early);
    modelCmd("L", "-", "3", ok);
  endtask

  task automatic test_back_to_back;
    int acks, errs;
    bit ok;
    @(posedge clk); #1;
    chr_cmd = "D"; chr_val0 = "3"; chr_val1 = "5"; rx_msg_done = 1'b1;
    @(posedge clk); #1 rx_msg_done = 1'b0;
    @(posedge clk); #1 rx_msg_done = 1'b1;
    @(posedge clk); #1 rx_msg_done = 1'b0;
    acks = int'(cmd_ack); errs = int'(cfg_err);
    repeat (8) begin @(posedge clk); #1 acks += int'(cmd_ack); errs += int'(cfg_err); end
    modelCmd("D", "3", "5", ok);
    tests++;
    if (acks != 1 || errs != 0 || min_hum !== 8'(mMinH)) begin
      fails++; $display("[TB] FAIL back_to_back got acks=%0d errs=%0d min_hum=%0d want 1 0 %0d",
                        acks, errs, min_hum, mMinH);
    end
  endtask

  task automatic test_invalid;
    logic [7:0] cs[4] = '{"X", "C", "A", "L"};
    logic [7:0] v0s[4] = '{"1", "-", "5", "2"};
    logic [7:0] v1s[4] = '{"2", "5", "1", "0"};
    logic a, e, early;
    bit ok;
    for (int i = 0; i < 4; i++) begin
      sendMsg(cs[i], v0s[i], v1s[i], 0, a, e, early);
      modelCmd(cs[i], v0s[i], v1s[i], ok);
      tests++;
      if ({a, e} !== {ok, !ok} || {max_temp, min_temp, max_hum, min_hum} !==
          {8'(mMaxT), 8'(mMinT), 8'(mMaxH), 8'(mMinH)} ||
          {manual_mode, fan_state, hum_state} !== {mManual, mFan, mHum}) begin
        fails++; $display("[TB] FAIL invalid_%0d got ack=%b err=%b sp=%0d/%0d/%0d/%0d want ack=%b err=%b sp=%0d/%0d/%0d/%0d",
                          i, a, e, max_temp, min_temp, max_hum, min_hum, ok, !ok, mMaxT, mMinT, mMaxH, mMinH);
      end
    end
  endtask

  task automatic test_random_cmds;
    logic [7:0] c, v0, v1;
    logic a, e, early;
    bit ok;
    int k;
    for (int i = 0; i < 30; i++) begin
      k  = int'($urandom_range(0, 4));
      c  = (k == 4) ? 8'h58 : 8'(8'h41 + k);
      v0 = ($urandom_range(0, 9) == 0) ? 8'h2D : 8'(8'h30 + $urandom_range(0, 9));
      v1 = 8'(8'h30 + $urandom_range(0, 9));
      sendMsg(c, v0, v1, 0, a, e, early);
      modelCmd(c, v0, v1, ok);
      tests++;
      if ({a, e} !== {ok, !ok} || {max_temp, min_temp, max_hum, min_hum} !==
          {8'(mMaxT), 8'(mMinT), 8'(mMaxH), 8'(mMinH)}) begin
        fails++; $display("[TB] FAIL rand_cmd %c%c%c got ack=%b err=%b sp=%0d/%0d/%0d/%0d want ack=%b err=%b sp=%0d/%0d/%0d/%0d",
                          c, v0, v1, a, e, max_temp, min_temp, max_hum, min_hum, ok, !ok, mMaxT, mMinT, mMaxH, mMinH);
      end
    end
  endtask

  task automatic test_random_sensor;
    int t, h;
    for (int i = 0; i < 40; i++) begin
      t = int'($urandom_range(0, 60));
      h = int'($urandom_range(0, 99));
      sensorStep(t, h);
      modelSensor(t, h);
      tests++;
      if ({fan_state, hum_state} !== {mFan, mHum}) begin
        fails++; $display("[TB] FAIL rand_sensor t=%0d h=%0d got fan=%b hum=%b want %b %b",
                          t, h, fan_state, hum_state, mFan, mHum);
      end
    end
  endtask

  task automatic test_reset_mid_manual;
    logic a, e, early;
    bit ok;
    sendMsg("L", "1", "1", 0, a, e, early);
    modelCmd("L", "1", "1", ok);
    @(posedge clk); #1 rst = 1'b1; rx_msg_done = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({manual_mode, fan_state, hum_state, cmd_ack, cfg_err} !== 5'b00000 ||
        {max_temp, min_temp, max_hum, min_hum} !== {8'd30, 8'd20, 8'd70, 8'd40}) begin
      fails++; $display("[TB] FAIL reset_mid_manual got man=%b fan=%b hum=%b sp=%0d/%0d/%0d/%0d want 000 30/20/70/40",
                        manual_mode, fan_state, hum_state, max_temp, min_temp, max_hum, min_hum);
    end
    rx_msg_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_setpoint();
    test_auto_hysteresis();
    test_manual();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    test_invalid();
    test_random_cmds();
    test_random_sensor();
    test_reset_mid_manual();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/climate_ctrl.md
Name: climate_ctrl

Overview:
- Configuration and actuation controller placed behind the UART string interface.
- Consumes parsed RX commands (chr_cmd, chr_val0, chr_val1, rx_msg_done) and maintains four setpoint registers.
- Drives fan_state/hum_state from DHT11 samples using hysteresis, with a manual-override mode that times out.
- Its fan_state/hum_state outputs feed back into the UART TX status string.

Parameters:
DEF_MAX_TEMP, 30, reset value of max_temp (°C)
DEF_MIN_TEMP, 20, reset value of min_temp (°C)
DEF_MAX_HUM, 70, reset value of max_hum (%)
DEF_MIN_HUM, 40, reset value of min_hum (%)
TICK_CYCLES, 1_000_000, clk_1Mhz cycles per 1-second tick
MANUAL_TIMEOUT_S, 60, seconds of manual mode before automatic return to auto

Ports:
clk_1Mhz  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
chr_cmd  in  8  ASCII command char ('A','B','C','D','L')
chr_val0  in  8  ASCII first value char ('0'-'9' or '-')
chr_val1  in  8  ASCII second value char ('0'-'9')
rx_msg_done  in  1  level flag; rising edge = new complete message
temperature  in  8  unsigned °C, binary
humidity  in  8  unsigned %, binary
sensor_valid  in  1  one-cycle pulse: new temperature/humidity sample
fan_state  out  1  cooling fan on
hum_state  out  1  humidifier on
max_temp, min_temp, max_hum, min_hum  out  8 each  current setpoints, binary
manual_mode  out  1  override active
cmd_ack  out  1  one-cycle pulse: command applied
cfg_err  out  1  one-cycle pulse: command rejected

Behaviour:
- Reset (rst=1 at a clock edge):
  - Setpoints = DEF_*.
  - fan_state=0, hum_state=0, manual_mode=0, cmd_ack=0, cfg_err=0.
  - FSM=IDLE, tick and timeout counters = 0.
  - rx_msg_done history register = 1, so a flag already high at reset release is not treated as a new message.
  - Reset applies the same way mid-command or mid-manual-mode.
- Command FSM: IDLE -> DECODE -> APPLY -> IDLE.
  - IDLE: rx_msg_done=1 with history=0 at edge N -> capture the chr_* inputs, go to DECODE.
  - DECODE (edge N+1):
    - val = (val0-0x30)*10 + (val1-0x30), 7 bits, range 0..99.
    - Flag non-digit chars.
  - APPLY (edge N+2): write the setpoint or reject. cmd_ack or cfg_err is high for exactly the cycle after edge N+2. Return to IDLE.
  - A rising edge while not in IDLE is dropped; no pulse is generated.
- Validation (any failure -> cfg_err, no register change):
  - 'A' max_temp: digits only, val<=50, val>min_temp.
  - 'B' min_temp: digits only, val<=50, val<max_temp.
  - 'C' max_hum: digits only, val>min_hum.
  - 'D' min_hum: digits only, val<max_hum.
  - 'L':
    - val0 in {'0','1'} and val1 in {'0','1'}: fan_state=val0 bit, hum_state=val1 bit, manual_mode=1, timeout counters cleared. Also applies while already manual, which restarts the timeout.
    - val0='-' and val1 any digit: manual_mode=0, outputs hold their values.
    - Anything else: reject.
  - Any other chr_cmd: reject.
- Auto control:
  - Active only while manual_mode=0 and sensor_valid=1.
  - Compares use the setpoint values registered before the current edge.
  - Fan: temperature>max_temp -> 1; temperature<min_temp -> 0; otherwise hold.
  - Humidifier: humidity<min_hum -> 1; humidity>=max_hum -> 0; otherwise hold.
- Manual mode:
  - sensor_valid is ignored.
  - Tick counter counts 0..TICK_CYCLES-1. On wrap, the seconds counter increments.
  - Seconds counter reaching MANUAL_TIMEOUT_S -> manual_mode=0 and both counters cleared. Outputs hold until the next sensor_valid.
  - Counters stay at 0 while in auto mode.
- Simultaneous events:
  - An APPLY of 'L' and sensor_valid in the same cycle: 'L' wins (outputs take the 'L' values).
  - A timeout expiry and an 'L' APPLY in the same cycle: 'L' wins (manual mode stays active with a fresh timeout).

Test Plan:
- Reset with rx_msg_done held at 1, then release -> no cmd_ack/cfg_err; setpoints read 30/20/70/40; fan_state=0, hum_state=0.
- Message 'A','2','8' (rx_msg_done rises at edge N) -> cmd_ack in the cycle after edge N+2; max_temp=28. Then 'B','2','8' -> cfg_err; min_temp stays 20.
- Auto hysteresis with defaults, sensor_valid per step:
  - temperature 31 -> fan=1; 25 -> fan=1; 19 -> fan=0.
  - humidity 39 -> hum=1; 55 -> hum=1; 70 -> hum=0.
- 'L','1','0' -> manual_mode=1, fan=1, hum=0. Then temperature 10 with sensor_valid -> fan stays 1. Then 'L','-','0' -> manual_mode=0.
- Manual timeout with TICK_CYCLES=10, MANUAL_TIMEOUT_S=3:
  - 'L','0','1' -> manual_mode drops to 0 exactly 30 cycles after the APPLY cycle.
  - A second 'L' at cycle 20 restarts the count.
- Invalid inputs each give cfg_err with no state change: 'X','1','2'; 'C','-','5'; 'A','5','1'; 'L','2','0'.
- A second rx_msg_done edge one cycle after the first is dropped: exactly one cmd_ack.
